shift_register_n: RTL and testbench
===================================

# shift_register_n

Parametrised universal shift register with an enable, the successor to the single-bit enabled register. It holds a WIDTH-bit word and supports hold, parallel load, logical shifts, rotates and clear. A built-in burst serialiser shifts a loaded word out LSB-first with a busy/done handshake. It sits between parallel datapath logic and serial links or bit-serial units.

## Interface
- WIDTH, 8: register width in bits; legal values are 2 and above.
- RST_VAL, 0: value loaded into q on reset; WIDTH bits.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; **synchronous, active-high**.
- en  in  1  operation enable; when 0, all state holds, except that done still clears.
- mode  in  3  operation select when idle: 000 hold, 001 load, 010 shl, 011 shr, 100 rol, 101 ror, 110 clear, 111 hold.
- d  in  WIDTH  parallel load data, used for both load and burst start.
- sin  in  1  serial input.
- start  in  1  burst request; sampled only when en=1 and the block is idle.
- q  out  WIDTH  register contents.
- sout  out  1  serial output; combinational copy of q[0] in every state.
- busy  out  1  a burst is in progress.
- done  out  1  one-cycle pulse on burst completion.

## Operation
- States: IDLE and SHIFT. Bit counter cnt is $clog2(WIDTH+1) bits wide.
- **IDLE, en=1, start=0:** mode is applied at the edge.
  - shl: q <= {q[W-2:0], sin}.
  - shr: q <= {sin, q[W-1:1]}.
  - rol: q <= {q[W-2:0], q[W-1]}.
  - ror: q <= {q[0], q[W-1:1]}.
  - clear: q <= 0.
  - hold and 111: q unchanged.
- **IDLE, en=1, start=1:** start overrides mode.
  - q <= d, cnt <= 0, state <= SHIFT, busy <= 1.
- **SHIFT, en=1:**
  - q <= {sin, q[W-1:1]}, cnt <= cnt+1.
  - When cnt == WIDTH-1 at the edge, that shift is the last one: state <= IDLE, busy <= 0, done <= 1.
- **SHIFT, en=0:** q, cnt and state are frozen; the burst pauses.
- In SHIFT, mode and start are ignored. A repeated start is dropped, not queued.
- done is high for exactly one cycle and clears on the next edge regardless of en.
- **Reset:** q=RST_VAL, state=IDLE, cnt=0, busy=0, done=0, sout=RST_VAL[0].
  - Reset overrides en, start and mode.
  - Reset during SHIFT aborts the burst; no done is issued.

## Timing
- Mode operations have 1-cycle latency: the result is visible on q the cycle after the sampling edge.
- **Burst start and output:**
  - start is sampled at edge k; busy is high from edge k.
  - sout presents d[0], d[1] … d[W-1] in the W enabled cycles that follow.
  - Each bit is held until the next enabled edge.
- **Burst end:**
  - busy falls and done rises at the W-th enabled edge after k.
  - busy is high for W cycles plus the number of en=0 cycles during the burst.
  - At completion, q holds the last W sin values, with the oldest in the LSB.
- **Back-to-back bursts:** start in the done cycle is accepted, since the block is idle. The minimum burst period is W+1 cycles.
- **en=0 in the done cycle:** done still falls at the next edge, and no new start is accepted.

## Test plan
- **Reset:** hold rst high for 1 edge mid-activity, with RST_VAL=0x00. Expect q=0x00, busy=0, done=0, sout=0 on the next cycle.
- **Load and enable:**
  - Load 0xA5 with mode=001, en=1. Expect q=0xA5.
  - Then mode=001, d=0x3C, en=0. Expect q to stay 0xA5.
- **Shifts and rotates from 0xA5:**
  - shl with sin=1 gives 0x4B.
  - shr with sin=0 gives 0x52.
  - rol gives 0x4B.
  - ror gives 0xD2.
  - clear gives 0x00.
  - mode=111 gives no change.
- **Burst:** d=0xB4, start=1 for one edge, sin=0.
  - sout sequence is 0,0,1,0,1,1,0,1.
  - busy is high for 8 cycles, then done is high for 1 cycle.
  - Final q=0x00.
- **Paused burst:** same stimulus with en=0 for 3 cycles after the 3rd bit; also raise start and set mode=110 during busy.
  - The bit sequence is unchanged.
  - busy is high for 11 cycles and a single done pulse follows.
  - The extra start and the mode change have no effect.
- **Reset abort:** assert rst in the 4th busy cycle of a 0xFF burst.
  - Next cycle: q=RST_VAL, busy=0.
  - done is never asserted.

Source files
------------

// File: rtl/shift_register_n.sv
// Universal WIDTH-bit shift register with hold/load/shift/rotate/clear and a
// burst serialiser that shifts a loaded word out LSB-first with busy/done.
module shift_register_n #(
  parameter int unsigned         WIDTH   = 8,
  parameter logic [WIDTH-1:0]    RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  input  logic             start,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done,
  output logic             dbg_state
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] q_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] idle_d;
  logic [WIDTH-1:0] shift_d;

  // Serial shift used by both shr and the burst: sin enters at the MSB.
  assign shift_d = {sin, q_q[WIDTH-1:1]};

  always_comb begin
    idle_d = q_q;
    case (mode)
      3'b001:  idle_d = d;
      3'b010:  idle_d = {q_q[WIDTH-2:0], sin};
      3'b011:  idle_d = shift_d;
      3'b100:  idle_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
      3'b101:  idle_d = {q_q[0], q_q[WIDTH-1:1]};
      3'b110:  idle_d = '0;
      default: idle_d = q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q     <= RST_VAL;
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // done is a single-cycle pulse and falls even while en is low.
      done_q <= 1'b0;
      if (en) begin
        case (state_q)
          IDLE: begin
            if (start) begin
              q_q     <= d;
              cnt_q   <= '0;
              state_q <= SHIFT;
              busy_q  <= 1'b1;
            end else begin
              q_q <= idle_d;
            end
          end
          SHIFT: begin
            q_q   <= shift_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign q         = q_q;
  assign sout      = q_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_shift_register_n.sv
// Self-checking bench for shift_register_n: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_shift_register_n;

  localparam int W = 8;
  localparam logic [W-1:0] RV = 8'h00;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic [2:0]   mode = 3'd0;
  logic [W-1:0] d = '0;
  logic         sin = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] q;
  logic         sout, busy, done, dbg_state;

  int vectors = 0;
  int errors  = 0;

  logic [W-1:0] m_q = RV;
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  int           m_rem = 0;

  logic [0:0] exp_q[$];

  shift_register_n #(.WIDTH(W), .RST_VAL(RV)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .sin(sin),
    .start(start), .q(q), .sout(sout), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Reference behaviour: plain arithmetic on the word plus a remaining-bits count.
  function automatic void model_step();
    logic [W-1:0] s;
    s = {7'b0, sin};
    if (rst) begin
      m_q = RV; m_busy = 0; m_done = 0; m_rem = 0;
    end else begin
      m_done = 0;
      if (en) begin
        if (m_busy) begin
          m_q = (m_q >> 1) | (s << (W - 1));
          m_rem = m_rem - 1;
          if (m_rem == 0) begin m_busy = 0; m_done = 1; end
        end else if (start) begin
          m_q = d; m_busy = 1; m_rem = W;
        end else begin
          case (mode)
            3'd1: m_q = d;
            3'd2: m_q = (m_q << 1) | s;
            3'd3: m_q = (m_q >> 1) | (s << (W - 1));
            3'd4: m_q = (m_q << 1) | (m_q >> (W - 1));
            3'd5: m_q = (m_q >> 1) | (m_q << (W - 1));
            3'd6: m_q = '0;
            default: m_q = m_q;
          endcase
        end
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    en = 1;
    for (int i = 0; i < 6; i++) begin
      mode = 3'($urandom_range(0, 7)); d = W'($urandom); sin = 1'($urandom);
      start = (i == 3);
      tick();
    end
    start = 0; rst = 1; tick(); rst = 0;
    vectors++; if (q !== RV) begin errors++; $display("FAIL reset_q: got %h want %h", q, RV); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (sout !== RV[0]) begin errors++; $display("FAIL reset_sout: got %b want %b", sout, RV[0]); end
  endtask

  task automatic test_load_enable();
    mode = 3'd1; d = 8'hA5; en = 1; tick();
    vectors++; if (q !== 8'hA5) begin errors++; $display("FAIL load: got %h want a5", q); end
    d = 8'h3C; en = 0; tick();
    vectors++; if (q !== 8'hA5) begin errors++; $display("FAIL en_hold: got %h want a5", q); end
    en = 1;
  endtask

  task automatic test_shifts();
    logic [2:0]   t_mode[6] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    logic         t_sin[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [W-1:0] t_exp[6]  = '{8'h4B, 8'h52, 8'h4B, 8'hD2, 8'h00, 8'hA5};
    for (int i = 0; i < 6; i++) begin
      en = 1; mode = 3'd1; d = 8'hA5; tick();
      mode = t_mode[i]; sin = t_sin[i]; tick();
      vectors++;
      if (q !== t_exp[i]) begin
        errors++; $display("FAIL shift_mode%0d: got %h want %h", t_mode[i], q, t_exp[i]);
      end
    end
    mode = 3'd0;
  endtask

  // Runs one burst of word w with sin=0; optionally pauses 3 cycles after bit 3
  // while hammering start and mode=clear.
  task automatic run_burst(input logic [W-1:0] w, input bit pause, input int exp_busy);
    int c = 0;
    int bcnt = 0;
    exp_q.delete();
    for (int i = 0; i < W; i++) exp_q.push_back(w[i]);
    en = 1; mode = 3'd0; sin = 0; d = w; start = 1; tick(); start = 0;
    while (busy === 1'b1 && c < 40) begin
      if (pause && c >= 3) begin start = 1; mode = 3'd6; end
      en = !(pause && c >= 3 && c < 6);
      bcnt++;
      vectors++;
      if (exp_q.size() == 0 || sout !== exp_q[0]) begin
        errors++; $display("FAIL burst_sout c=%0d: got %b want %b", c, sout, exp_q.size() ? exp_q[0] : 1'bx);
      end
      if (en && exp_q.size() != 0) void'(exp_q.pop_front());
      tick(); c++;
    end
    vectors++; if (bcnt != exp_busy) begin errors++; $display("FAIL burst_busy_len: got %0d want %0d", bcnt, exp_busy); end
    vectors++; if (done !== 1'b1) begin errors++; $display("FAIL burst_done: got %b want 1", done); end
    vectors++; if (q !== 8'h00) begin errors++; $display("FAIL burst_q: got %h want 00", q); end
    start = 0; mode = 3'd0; en = 1; tick();
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL burst_done_pulse: got %b want 0", done); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL burst_restart: got %b want 0", busy); end
  endtask

  task automatic test_burst();
    run_burst(8'hB4, 1'b0, 8);
  endtask

  task automatic test_paused_burst();
    run_burst(8'hB4, 1'b1, 11);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w2;
    int c = 0;
    en = 1; d = W'($urandom); start = 1; tick(); start = 0;
    while (busy === 1'b1 && c < 20) begin sin = 1'($urandom); tick(); c++; end
    vectors++; if (done !== 1'b1 || q !== m_q) begin errors++; $display("FAIL b2b_first: done=%b q=%h want 1 %h", done, q, m_q); end
    w2 = W'($urandom); d = w2; start = 1; tick(); start = 0;
    vectors++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b_accept: busy=%b done=%b want 1 0", busy, done); end
    vectors++; if (sout !== w2[0]) begin errors++; $display("FAIL b2b_sout0: got %b want %b", sout, w2[0]); end
    c = 0;
    while (busy === 1'b1 && c < 20) begin sin = 1'($urandom); tick(); c++; end
    vectors++; if (c != W || q !== m_q) begin errors++; $display("FAIL b2b_second: cycles=%0d q=%h want %0d %h", c, q, W, m_q); end
    en = 0; start = 1; d = W'($urandom); tick();
    vectors++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL done_en0: done=%b busy=%b want 0 0", done, busy); end
    start = 0; en = 1;
  endtask

  task automatic test_abort();
    int seen_done = 0;
    en = 1; mode = 3'd0; d = 8'hFF; start = 1; tick(); start = 0;
    for (int i = 0; i < 3; i++) tick();
    rst = 1; tick(); rst = 0;
    vectors++; if (q !== RV || busy !== 1'b0) begin errors++; $display("FAIL abort: q=%h busy=%b want %h 0", q, busy, RV); end
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) seen_done++;
      tick();
    end
    vectors++; if (seen_done != 0) begin errors++; $display("FAIL abort_no_done: saw %0d want 0", seen_done); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      en    = ($urandom_range(0, 3) != 0);
      mode  = 3'($urandom_range(0, 7));
      d     = W'($urandom);
      sin   = 1'($urandom);
      start = ($urandom_range(0, 5) == 0);
      tick();
      vectors++;
      if (q !== m_q || busy !== m_busy || done !== m_done || sout !== m_q[0] || dbg_state !== m_busy) begin
        errors++;
        $display("FAIL random i=%0d: q=%h busy=%b done=%b sout=%b st=%b want %h %b %b %b", i, q, busy, done, sout,
                 dbg_state, m_q, m_busy, m_done, m_q[0]);
      end
    end
    rst = 0; start = 0;
  endtask

  initial begin
    rst = 1; tick(); tick(); rst = 0;
    test_reset();
    test_load_enable();
    test_shifts();
    test_burst();
    test_paused_burst();
    test_back_to_back();
    test_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
